// File: rtl/fft_frame_loader_if.sv
// Valid/busy stream bundle for fft_frame_loader, one instance per side.
// Ports: valid, busy, re, im (W bits each), last; master drives data, slave drives busy.
interface fft_frame_loader_if #(
   parameter int W = 16
);
   logic         valid;
   logic         busy;
   logic [W-1:0] re;
   logic [W-1:0] im;
   logic         last;

   modport master (
      output valid, re, im, last,
      input  busy
   );

   modport slave (
      input  valid, re, im, last,
      output busy
   );
endinterface

// File: rtl/fft_frame_loader.sv
// Serial-to-parallel frame loader: gathers 2**NPOINT complex samples into one vector.
// Ports: clk, rst_n (sync, active-low), din (sample stream, slave),
//        dout (frame vector, master, lane i at [i*WIDTH +: WIDTH]), frame_err (pulse).
// Option: define FFT_FRAME_LOADER_BITREV_EN to place sample k in lane bitrev(k).
module fft_frame_loader #(
   parameter int WIDTH  = 16,
   parameter int NPOINT = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   fft_frame_loader_if.slave   din,
   fft_frame_loader_if.master  dout,
   output logic                frame_err
);
   localparam int N = 1 << NPOINT;

   logic [NPOINT-1:0]  cnt;
   logic [NPOINT-1:0]  lane;
   logic               full;
   logic               out_valid;
   logic [N*WIDTH-1:0] out_re;
   logic [N*WIDTH-1:0] out_im;
   logic [N*WIDTH-1:0] vec_re;
   logic [N*WIDTH-1:0] vec_im;
   logic [WIDTH-1:0]   buf_re [N];
   logic [WIDTH-1:0]   buf_im [N];
   logic               din_tran;
   logic               dout_tran;
   logic               move;
   logic               at_end;

`ifdef FFT_FRAME_LOADER_BITREV_EN
   function automatic logic [NPOINT-1:0] bitrev(
      input logic [NPOINT-1:0] k
   );
      logic [NPOINT-1:0] r;
      for (int i = 0; i < NPOINT; i++)
         r[i] = k[NPOINT-1-i];
      return r;
   endfunction

   assign lane = bitrev(cnt);
`else
   assign lane = cnt;
`endif

   assign din_tran  = din.valid && !full;
   assign dout_tran = out_valid && !dout.busy;
   // Collect buffer may hand over in the same edge the output drains.
   assign move      = full && (!out_valid || dout_tran);
   assign at_end    = (cnt == NPOINT'(N-1));

   assign din.busy   = full;
   assign dout.valid = out_valid;
   assign dout.re    = out_re;
   assign dout.im    = out_im;
   assign dout.last  = 1'b1;

   always_comb begin
      vec_re = '0;
      vec_im = '0;
      for (int i = 0; i < N; i++) begin
         vec_re[i*WIDTH +: WIDTH] = buf_re[i];
         vec_im[i*WIDTH +: WIDTH] = buf_im[i];
      end
   end

   // Slot contents are don't-care until cnt says they were written.
   always_ff @(posedge clk) begin
      if (din_tran) begin
         buf_re[lane] <= din.re;
         buf_im[lane] <= din.im;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt       <= '0;
         full      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (move)
            full <= 1'b0;
         if (din_tran) begin
            if (at_end) begin
               cnt       <= '0;
               full      <= 1'b1;
               frame_err <= !din.last;
            end else if (din.last) begin
               cnt       <= '0;
               frame_err <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
      end else if (move) begin
         out_valid <= 1'b1;
         out_re    <= vec_re;
         out_im    <= vec_im;
      end else if (dout_tran) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fft_frame_loader.sv
// Randomized bench for fft_frame_loader against a queue-based frame model.
// Ports: drives din/dout interfaces, clk and rst_n of the loader.
module tb_fft_frame_loader;
   localparam int WIDTH  = 16;
   localparam int NPOINT = 3;
   localparam int N      = 1 << NPOINT;
   localparam int VW     = WIDTH * N;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic frame_err;

   fft_frame_loader_if #(.W(WIDTH)) din_if ();
   fft_frame_loader_if #(.W(VW))    dout_if ();

   fft_frame_loader #(
      .WIDTH  (WIDTH),
      .NPOINT (NPOINT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din_if),
      .dout      (dout_if),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit rnd_busy = 0;

   task automatic chk(
      input string           tag,
      input logic [VW-1:0]   got,
      input logic [VW-1:0]   exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   function automatic int lane_of(input int k);
`ifdef FFT_FRAME_LOADER_BITREV_EN
      int r = 0;
      for (int b = 0; b < NPOINT; b++)
         if (((k >> b) & 1) != 0)
            r |= 1 << (NPOINT - 1 - b);
      return r;
`else
      return k;
`endif
   endfunction

   // Reference model: samples accumulate in a list; a full list becomes
   // an expected vector, a list closed early by last is dropped.
   logic [WIDTH-1:0] cur_re [$];
   logic [WIDTH-1:0] cur_im [$];
   logic [VW-1:0]    exp_re [$];
   logic [VW-1:0]    exp_im [$];
   logic             pend_err = 1'b0;
   logic             prev_hold = 1'b0;
   logic [VW-1:0]    prev_re;
   logic [VW-1:0]    prev_im;
   int               frames_out = 0;
   int               frames_exp = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         cur_re.delete();
         cur_im.delete();
         exp_re.delete();
         exp_im.delete();
         pend_err  = 1'b0;
         prev_hold = 1'b0;
      end else begin
         chk("frame_err", VW'(frame_err), VW'(pend_err));
         pend_err = 1'b0;
         if (prev_hold) begin
            chk("hold_valid", VW'(dout_if.valid), VW'(1));
            chk("hold_re", dout_if.re, prev_re);
            chk("hold_im", dout_if.im, prev_im);
         end
         if (dout_if.valid && !dout_if.busy) begin
            if (exp_re.size() == 0) begin
               chk("spurious_frame", VW'(1), VW'(0));
            end else begin
               chk("dout_re", dout_if.re, exp_re.pop_front());
               chk("dout_im", dout_if.im, exp_im.pop_front());
               frames_out++;
            end
         end
         prev_hold = dout_if.valid && dout_if.busy;
         prev_re   = dout_if.re;
         prev_im   = dout_if.im;
         if (din_if.valid && !din_if.busy) begin
            cur_re.push_back(din_if.re);
            cur_im.push_back(din_if.im);
            if (cur_re.size() == N) begin
               logic [VW-1:0] vr;
               logic [VW-1:0] vi;
               vr = '0;
               vi = '0;
               for (int k = 0; k < N; k++) begin
                  vr[lane_of(k)*WIDTH +: WIDTH] = cur_re[k];
                  vi[lane_of(k)*WIDTH +: WIDTH] = cur_im[k];
               end
               exp_re.push_back(vr);
               exp_im.push_back(vi);
               frames_exp++;
               pend_err = !din_if.last;
               cur_re.delete();
               cur_im.delete();
            end else if (din_if.last) begin
               pend_err = 1'b1;
               cur_re.delete();
               cur_im.delete();
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_busy)
         dout_if.busy = ($urandom_range(0, 2) == 0);
   endtask

   task automatic send(
      input logic [WIDTH-1:0] re,
      input logic [WIDTH-1:0] im,
      input logic             last
   );
      int guard = 0;
      din_if.valid = 1'b1;
      din_if.re    = re;
      din_if.im    = im;
      din_if.last  = last;
      while (din_if.busy && guard < 200) begin
         tick();
         guard++;
      end
      if (guard >= 200)
         chk("din_timeout", VW'(1), VW'(0));
      tick();
      din_if.valid = 1'b0;
   endtask

   task automatic send_frame(
      input int n,
      input int base_re,
      input int base_im,
      input int last_idx,
      input bit gaps
   );
      for (int k = 0; k < n; k++) begin
         send(WIDTH'(base_re + k), WIDTH'(base_im - k),
              (k == last_idx));
         if (gaps)
            repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   function automatic logic [VW-1:0] ramp(input int base);
      logic [VW-1:0] v = '0;
      for (int k = 0; k < N; k++)
         v[lane_of(k)*WIDTH +: WIDTH] = WIDTH'(base + k);
      return v;
   endfunction

   task automatic drain();
      int guard = 0;
      rnd_busy = 0;
      dout_if.busy = 1'b0;
      while ((exp_re.size() != 0 || dout_if.valid) &&
             guard < 200) begin
         tick();
         guard++;
      end
      chk("drain", VW'(exp_re.size()), VW'(0));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, VW'(din_if.busy), VW'(0));
      chk({tag, "_valid"}, VW'(dout_if.valid), VW'(0));
      chk({tag, "_re"}, dout_if.re, VW'(0));
      chk({tag, "_im"}, dout_if.im, VW'(0));
      chk({tag, "_err"}, VW'(frame_err), VW'(0));
   endtask

   logic [VW-1:0] vec_a;

   initial begin
      din_if.valid = 1'b0;
      din_if.re    = '0;
      din_if.im    = '0;
      din_if.last  = 1'b0;
      dout_if.busy = 1'b0;
      repeat (2) tick();
      chk_zero("reset");
      rst_n = 1'b1;
      tick();

      // basic frame real=k, imag=-k
      send_frame(N, 0, 0, N-1, 0);
      chk("lat_busy", VW'(din_if.busy), VW'(1));
      chk("lat_valid0", VW'(dout_if.valid), VW'(0));
      tick();
      chk("lat_valid1", VW'(dout_if.valid), VW'(1));
      chk("lat_busy0", VW'(din_if.busy), VW'(0));
      chk("basic_re", dout_if.re, ramp(0));
      chk("basic_last", VW'(dout_if.last), VW'(1));
`ifdef FFT_FRAME_LOADER_BITREV_EN
      chk("brev_l1", VW'(dout_if.re[16 +: 16]), VW'(4));
      chk("brev_l3", VW'(dout_if.re[48 +: 16]), VW'(6));
      chk("brev_l4", VW'(dout_if.re[64 +: 16]), VW'(1));
      chk("brev_l6", VW'(dout_if.re[96 +: 16]), VW'(3));
`else
      chk("lane5_re", VW'(dout_if.re[80 +: 16]), VW'(5));
      chk("lane3_im", VW'(dout_if.im[48 +: 16]),
          VW'(16'hfffd));
`endif
      drain();

      // stall: A held at output while B fills
      dout_if.busy = 1'b1;
      send_frame(N, 'h50, 0, N-1, 0);
      repeat (2) tick();
      vec_a = ramp('h50);
      send_frame(N, 'h100, 0, N-1, 0);
      repeat (3) tick();
      chk("stall_busy", VW'(din_if.busy), VW'(1));
      chk("stall_hold", dout_if.re, vec_a);
      dout_if.busy = 1'b0;
      tick();
      dout_if.busy = 1'b1;
      chk("stall_moveb", dout_if.re, ramp('h100));
      chk("stall_valid", VW'(dout_if.valid), VW'(1));
      tick();
      chk("stall_free", VW'(din_if.busy), VW'(0));
      drain();

      // short frame: last on 5th sample
      send_frame(5, 'h70, 0, 4, 0);
      chk("short_err", VW'(frame_err), VW'(1));
      tick();
      chk("short_err_end", VW'(frame_err), VW'(0));
      chk("short_novalid", VW'(dout_if.valid), VW'(0));
      send_frame(N, 'h10, 0, N-1, 0);
      tick();
      chk("short_next", dout_if.re, ramp('h10));
      drain();

      // missing last
      send_frame(N, 'h30, 0, -1, 0);
      chk("miss_err", VW'(frame_err), VW'(1));
      tick();
      chk("miss_err_end", VW'(frame_err), VW'(0));
      send_frame(N, 'h40, 0, N-1, 0);
      drain();

      // reset mid-frame
      send_frame(3, 'h90, 0, -1, 0);
      rst_n = 1'b0;
      tick();
      chk_zero("midrst");
      rst_n = 1'b1;
      send_frame(N, 'h20, 0, N-1, 1);
      tick();
      chk("rst_lane0", VW'(dout_if.re[0 +: 16]), VW'('h20));
      drain();

      // random frames, gaps and downstream stalls
      rnd_busy = 1;
      for (int f = 0; f < 40; f++) begin
         int kind = $urandom_range(0, 9);
         int br   = $urandom;
         int bi   = $urandom;
         if (kind == 0)
            send_frame($urandom_range(1, N-1), br, bi,
                       -2, 1);
         else if (kind == 1)
            send_frame(N, br, bi, -1, 1);
         else
            send_frame(N, br, bi, N-1, 1);
         if (kind == 0) begin
            din_if.valid = 1'b1;
            din_if.re    = WIDTH'($urandom);
            din_if.last  = 1'b1;
            send(din_if.re, WIDTH'(bi), 1'b1);
         end
      end
      drain();
      repeat (3) tick();
      chk("frame_count", VW'(frames_out), VW'(frames_exp));

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
